// File: rtl/binary_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package binary_to_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
    function automatic bit digits_sufficient(input int width, input int digits);
        longint max_bin;
        longint pow10;
        max_bin = (longint'(1) <<< width) - 1;
        pow10   = 1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 10;
        end
        return pow10 > max_bin;
    endfunction

endpackage

// File: rtl/binary_to_bcd_fsm_add3.sv
// One double-dabble digit corrector: adds 3 when the digit is 5 or more.
module bcd_add3_digit
    import binary_to_bcd_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    // Input never exceeds 9, so the sum fits in 4 bits.
    assign digit_out = (digit_in >= ADD3_THRESH) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/binary_to_bcd_fsm.sv
// Sequential shift-and-add-3 binary-to-BCD converter with start/busy/done handshake.
// Optional leading-zero blank mask output enabled by B2BCD_ZERO_BLANK_EN.
module binary_to_bcd_fsm
    import binary_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
`ifdef B2BCD_ZERO_BLANK_EN
    output logic [DIGITS-1:0]     blank_mask,
`endif
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    if (!digits_sufficient(WIDTH, DIGITS)) begin : g_bad_params
        $error("binary_to_bcd_fsm: DIGITS too small for WIDTH");
    end

    state_t             state_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [SCR_W-1:0]   bcd_reg;
    logic [SCR_W-1:0]   scratch_reg;
    logic [WIDTH-1:0]   bin_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [SCR_W-1:0]   scratch_adj;
    logic [SCR_W-1:0]   scratch_next;
    logic               accept;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_in  (scratch_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (scratch_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The bit leaving the top of the scratch field is always zero.
    assign scratch_next = {scratch_adj[SCR_W-2:0], bin_reg[WIDTH-1]};
    assign accept       = start && (state_reg == IDLE || state_reg == DONE);

`ifdef B2BCD_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_reg;
    logic [DIGITS-1:0] blank_next;

    assign blank_next[0] = 1'b0;
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_blank
        assign blank_next[gi] = (scratch_next[SCR_W-1:gi*BCD_DIGIT_W] == '0);
    end
    assign blank_mask = blank_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            bcd_reg     <= '0;
            scratch_reg <= '0;
            bin_reg     <= '0;
            cnt_reg     <= '0;
`ifdef B2BCD_ZERO_BLANK_EN
            blank_reg   <= '0;
`endif
        end else if (accept) begin
            state_reg   <= CONVERT;
            busy_reg    <= 1'b1;
            done_reg    <= 1'b0;
            bin_reg     <= bin_in;
            scratch_reg <= '0;
            cnt_reg     <= CNT_W'(WIDTH);
        end else begin
            case (state_reg)
                IDLE: begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                end
                CONVERT: begin
                    scratch_reg <= scratch_next;
                    bin_reg     <= bin_reg << 1;
                    cnt_reg     <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        bcd_reg   <= scratch_next;
`ifdef B2BCD_ZERO_BLANK_EN
                        blank_reg <= blank_next;
`endif
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign bcd_out = bcd_reg;

endmodule

// File: tb/tb_binary_to_bcd_fsm.sv
// Randomised self-checking bench for binary_to_bcd_fsm against a divide-by-ten model.
module tb_binary_to_bcd_fsm;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [WIDTH-1:0]  bin_in;
    logic              busy;
    logic              done;
    logic [BW-1:0]     bcd_out;
`ifdef B2BCD_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_mask;
`endif

    int total = 0;
    int bad   = 0;
    logic [BW-1:0] prev_bcd = '0;

    binary_to_bcd_fsm #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
`ifdef B2BCD_ZERO_BLANK_EN
        .blank_mask (blank_mask),
`endif
        .bcd_out    (bcd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] model_bcd(input int value);
        logic [BW-1:0] r;
        int v;
        r = '0;
        v = value;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] model_blank(input int value);
        logic [DIGITS-1:0] m;
        int p;
        m = '0;
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            m[i] = (value < p);
            p = p * 10;
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for done with a cycle budget; optionally pulse start mid-conversion.
    task automatic wait_done(input bit pulse, output int n);
        n = 0;
        while (!done && n <= WIDTH + 3) begin
            check("hold_during_convert", 32'(bcd_out), 32'(prev_bcd));
            if (pulse && n == 3) begin
                start  = 1'b1;
                bin_in = WIDTH'(7);
            end
            if (pulse && n == 4) start = 1'b0;
            step();
            n++;
        end
        if (!done) check("done_timeout", 32'(n), 32'(WIDTH));
    endtask

    task automatic check_result(input int value);
        check("bcd_out", 32'(bcd_out), 32'(model_bcd(value)));
        check("busy_at_done", 32'(busy), 32'd0);
`ifdef B2BCD_ZERO_BLANK_EN
        check("blank_mask", 32'(blank_mask), 32'(model_blank(value)));
`endif
        prev_bcd = model_bcd(value);
    endtask

    task automatic convert(input int value, input bit pulse);
        int n;
        start  = 1'b1;
        bin_in = WIDTH'(value);
        step();
        start  = 1'b0;
        bin_in = WIDTH'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        wait_done(pulse, n);
        check("latency", 32'(n), 32'(WIDTH));
        check_result(value);
        $display("conv in=%0d out=%0h cycles=%0d", value, bcd_out, n);
        step();
        check("done_one_cycle", 32'(done), 32'd0);
        if (pulse) begin
            for (int i = 0; i < 3; i++) begin
                step();
                check("no_extra_done", 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        int n1, n2;
        reset  = 1'b1;
        start  = 1'b1;
        bin_in = WIDTH'(255);
        step();
        step();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_bcd", 32'(bcd_out), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        convert(255, 1'b0);
        convert(0, 1'b0);
        convert(99, 1'b0);

        // Back-to-back with start held high; operand changes after first acceptance.
        start  = 1'b1;
        bin_in = WIDTH'(200);
        step();
        bin_in = WIDTH'(57);
        wait_done(1'b0, n1);
        check("b2b_latency1", 32'(n1), 32'(WIDTH));
        check_result(200);
        step();
        start = 1'b0;
        check("b2b_reaccept_busy", 32'(busy), 32'd1);
        check("b2b_reaccept_done", 32'(done), 32'd0);
        wait_done(1'b0, n2);
        check("b2b_gap", 32'(n2 + 1), 32'(WIDTH + 1));
        check_result(57);
        $display("b2b out=%0h gap=%0d", bcd_out, n2 + 1);
        step();

        convert(128, 1'b1);

        // Abort mid-conversion.
        start  = 1'b1;
        bin_in = WIDTH'(173);
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_bcd", 32'(bcd_out), 32'd0);
        prev_bcd = '0;
        step();
        check("abort_no_done", 32'(done), 32'd0);
        convert(173, 1'b0);

        for (int t = 0; t < 25; t++) begin
            convert(int'($urandom_range(0, (1 << WIDTH) - 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
